// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M multiply/divide constants, funct3 codes and FSM encoding
package muldiv_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 5;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between issue logic and the multiply/divide unit
interface muldiv_if;
    import muldiv_pkg::*;
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_addr_out;
    logic            RegWEn;
    modport master (output start, flush, funct3, rs1_data, rs2_data, rd_addr_in,
                    input  busy, done, result, rd_addr_out, RegWEn);
    modport slave  (input  start, flush, funct3, rs1_data, rs2_data, rd_addr_in,
                    output busy, done, result, rd_addr_out, RegWEn);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_n
);
    logic [XLEN:0]   sum;
    logic [XLEN+1:0] diff;
    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? b : {XLEN{1'b0}}};
        diff  = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, b};
        acc_n = is_div ? (diff[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0}
                                       : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                       : {sum, acc[XLEN-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle, result to register file
module muldiv_unit
    import muldiv_pkg::*;
(
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3;
    logic [4:0]        rd;
    logic              neg, done_q;
    logic [XLEN-1:0]   b, res, abs_a, abs_b, word, fixed;
    logic [2*XLEN-1:0] acc, acc_n, full;
    logic              sa, sb, ovf, fast, accept;
    muldiv_step u_step (.is_div(f3[2]), .acc(acc), .b(b), .acc_n(acc_n));
    always_comb begin
        sa     = bus.rs1_data[XLEN-1] & (bus.funct3 == F3_MULH || bus.funct3 == F3_MULHSU ||
                                         bus.funct3 == F3_DIV  || bus.funct3 == F3_REM);
        sb     = bus.rs2_data[XLEN-1] & (bus.funct3 == F3_MULH || bus.funct3 == F3_DIV ||
                                         bus.funct3 == F3_REM);
        abs_a  = sa ? -bus.rs1_data : bus.rs1_data;
        abs_b  = sb ? -bus.rs2_data : bus.rs2_data;
        ovf    = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM) &&
                 bus.rs1_data == {1'b1, {XLEN-1{1'b0}}} && bus.rs2_data == {XLEN{1'b1}};
        fast   = bus.funct3[2] & (bus.rs2_data == '0 || ovf);
        accept = state == IDLE && bus.start && !bus.flush;
        full   = (neg && !f3[2]) ? -acc : acc;
        word   = (f3 == F3_MUL || f3[2:1] == 2'b10) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        fixed  = (neg && f3[2]) ? -word : word;
    end
    always_comb begin
        state_n = state == IDLE ? (accept ? (fast ? FIN : RUN) : IDLE)
                : (state == RUN && !bus.flush && cnt != '1) ? RUN
                : (state == RUN && !bus.flush) ? FIN : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            f3     <= '0;
            rd     <= '0;
            neg    <= 1'b0;
            b      <= '0;
            acc    <= '0;
            res    <= '0;
            done_q <= 1'b0;
        end else begin
            if (accept) begin
                f3  <= bus.funct3;
                rd  <= bus.rd_addr_in;
                b   <= abs_b;
                neg <= !fast && (bus.funct3[2:1] == 2'b11 ? sa : sa ^ sb);
                cnt <= '0;
                // fast path parks {remainder, quotient} so FIN selects it like a normal divide
                acc <= fast ? {ovf ? {XLEN{1'b0}} : bus.rs1_data, ovf ? {1'b1, {XLEN-1{1'b0}}} : {XLEN{1'b1}}}
                            : {{XLEN{1'b0}}, abs_a};
            end else if (state == RUN) begin
                acc <= acc_n;
                cnt <= cnt + 1'b1;
            end
            if (state == FIN && !bus.flush) res <= fixed;
            done_q <= state == FIN && !bus.flush;
        end
    end
    assign bus.busy        = state != IDLE || done_q;
    assign bus.done        = done_q;
    assign bus.result      = res;
    assign bus.rd_addr_out = rd;
    assign bus.RegWEn      = done_q && rd != '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for the iterative multiply/divide unit
module tb_muldiv_unit;
    import muldiv_pkg::*;
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n;
    int   passed, total, lat, n;
    always #5 clk = ~clk;
    muldiv_if bus();
    muldiv_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    vec_t vecs[14] = '{
        '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33},
        '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33},
        '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
        '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33},
        '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
        '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
        '{F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33},
        '{F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33},
        '{F3_DIVU,   32'd100,      32'd7,        32'd14,       33},
        '{F3_REMU,   32'd100,      32'd7,        32'd2,        33},
        '{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1},
        '{F3_REM,    32'h1234,     32'd0,        32'h1234,     1},
        '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
        '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1}
    };
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_addr_in = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.funct3 = ~f3;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_addr_in = ~rd;
    endtask
    task automatic wait_done(output int l);
        l = 0;
        while (!bus.done && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask
    task automatic count_dones(input int cycles, output int c);
        c = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) c++;
        end
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        passed = 0;
        total = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.funct3 = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_addr_in = '0;
        #2;
        check("reset_ctl", {25'd0, bus.busy, bus.done, bus.RegWEn, bus.rd_addr_out}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            launch(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1));
            check($sformatf("busy_%0d", i), {31'd0, bus.busy}, 32'd1);
            wait_done(lat);
            check($sformatf("lat_%0d", i), lat, vecs[i].lat);
            check($sformatf("res_%0d", i), bus.result, vecs[i].r);
            check($sformatf("wen_%0d", i), {26'd0, bus.RegWEn, bus.rd_addr_out}, {26'd0, 1'b1, 5'(i + 1)});
            @(posedge clk);
            #1;
            check($sformatf("pulse_%0d", i), {31'd0, bus.done}, 32'd0);
        end
        launch(F3_MUL, 32'd3, 32'd4, 5'd9);
        wait_done(lat);
        check("b2b_first", bus.result, 32'd12);
        launch(F3_DIVU, 32'd100, 32'd7, 5'd10);
        wait_done(lat);
        check("b2b_lat", lat, 33);
        check("b2b_res", bus.result, 32'd14);
        launch(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        count_dones(40, n);
        check("flush_nodone", n, 0);
        check("flush_result", bus.result, 32'd14);
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", {31'd0, bus.busy}, 32'd0);
        launch(F3_DIV, 32'hFFFFFFF9, 32'd2, 5'd7);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.funct3 = F3_MUL;
        bus.rs1_data = 32'd3;
        bus.rs2_data = 32'd4;
        bus.rd_addr_in = 5'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        check("ignore_lat", lat + 6, 33);
        check("ignore_res", bus.result, 32'hFFFFFFFD);
        check("ignore_rd", {27'd0, bus.rd_addr_out}, 32'd7);
        launch(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ctl", {25'd0, bus.busy, bus.done, bus.RegWEn, bus.rd_addr_out}, 32'd0);
        check("arst_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_dones(40, n);
        check("arst_nodone", n, 0);
        launch(F3_MUL, 32'd3, 32'd4, 5'd6);
        wait_done(lat);
        check("post_rst_res", bus.result, 32'd12);
        check("post_rst_wen", {31'd0, bus.RegWEn}, 32'd1);
        launch(F3_MUL, 32'd5, 32'd6, 5'd0);
        wait_done(lat);
        check("rd0_res", bus.result, 32'd30);
        check("rd0_done_wen", {30'd0, bus.done, bus.RegWEn}, 32'd2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
